// File: rtl/z80_mailbox.sv
// z80_mailbox
//   Command/reply mailbox between the 68k host and the Z80 sound CPU.
//   The 68k writes a command byte. This sets CMD_PENDING and, if enabled, raises
//   an NMI to the Z80. The Z80 reads the command at port $00, or clears it by
//   writing port $00. It enables or disables the NMI through port $08/$18 and
//   posts a reply byte through port $0C.
//
// Ports
//   CLK, nRESET         clock; synchronous active-low reset
//   nSDW, M68K_DIN      68k command write strobe (active-low) and command byte
//   nM68K_RRD           68k reply-read strobe (active-low), clears OVERRUN
//   M68K_REPLY          reply byte returned to the 68k
//   nIORQ/nSDRD/nSDWR   Z80 I/O request, read and write strobes (active-low)
//   SDA_L[2:0]          Z80 address bits A4..A2 (SDA_L[0] = A2)
//   SDD_IN / SDD_OUT    Z80 data bus, write and read directions
//   nZ80NMI             NMI to the Z80 (active-low)
//   CMD_PENDING         command written and not yet taken by the Z80
//   OVERRUN             sticky: a command was written over an untaken one
module z80_mailbox (
  input  logic       CLK,
  input  logic       nRESET,
  input  logic       nSDW,
  input  logic [7:0] M68K_DIN,
  output logic [7:0] M68K_REPLY,
  input  logic       nM68K_RRD,
  input  logic       nIORQ,
  input  logic       nSDRD,
  input  logic       nSDWR,
  input  logic [2:0] SDA_L,
  input  logic [7:0] SDD_IN,
  output logic [7:0] SDD_OUT,
  output logic       nZ80NMI,
  output logic       CMD_PENDING,
  output logic       OVERRUN
);

  typedef enum logic [1:0] {NMI_IDLE, NMI_ARM, NMI_ASSERT} nmiState_t;

  // Bit positions of the edge-detected strobes.
  localparam int S_SDW    = 0;
  localparam int S_RRD    = 1;
  localparam int S_CMDRD  = 2;
  localparam int S_CMDCLR = 3;
  localparam int S_NMICFG = 4;
  localparam int S_REPWR  = 5;

  logic       ioRd, ioWr;
  logic [5:0] strobeLvl;    // strobe active this cycle (level)
  logic [5:0] strobePrev;   // level sampled on the previous edge
  logic [5:0] strobeBlock;  // held since reset; must be seen inactive first
  logic [5:0] strobeAct;    // one-cycle action pulse
  logic       cmdTaken;

  logic [7:0] cmd, reply;
  logic       cmdPending, overrun, nmiEn;
  nmiState_t  state, nextState;

  assign ioRd = !nIORQ && !nSDRD;
  assign ioWr = !nIORQ && !nSDWR;

  // SDA_L[1:0] are address bits A3..A2; SDA_L[2] is A4.
  assign strobeLvl[S_SDW]    = !nSDW;
  assign strobeLvl[S_RRD]    = !nM68K_RRD;
  assign strobeLvl[S_CMDRD]  = ioRd && (SDA_L[1:0] == 2'b00);
  assign strobeLvl[S_CMDCLR] = ioWr && (SDA_L[1:0] == 2'b00);
  assign strobeLvl[S_NMICFG] = ioWr && (SDA_L[1:0] == 2'b10);
  assign strobeLvl[S_REPWR]  = ioWr && (SDA_L[1:0] == 2'b11);

  // An action fires on the first active sample only. A strobe that was
  // already active across reset release stays blocked until it goes inactive.
  assign strobeAct = strobeLvl & ~strobePrev & ~strobeBlock;
  assign cmdTaken  = strobeAct[S_CMDRD] || strobeAct[S_CMDCLR];

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of the others regardless of order.
  always_ff @(posedge CLK) begin
    if (!nRESET) begin
      strobePrev  <= '0;
      strobeBlock <= '1;
      cmd         <= 8'h00;
      reply       <= 8'h00;
      cmdPending  <= 1'b0;
      overrun     <= 1'b0;
      nmiEn       <= 1'b0;
    end else begin
      strobePrev  <= strobeLvl;
      strobeBlock <= strobeBlock & strobeLvl;

      // A 68k write wins over a simultaneous Z80 read or clear.
      if (strobeAct[S_SDW]) begin
        cmd        <= M68K_DIN;
        cmdPending <= 1'b1;
      end else begin
        if (strobeAct[S_CMDCLR]) cmd <= 8'h00;
        if (cmdTaken)            cmdPending <= 1'b0;
      end

      // Setting OVERRUN has priority over a simultaneous reply read.
      if (strobeAct[S_SDW] && cmdPending) overrun <= 1'b1;
      else if (strobeAct[S_RRD])          overrun <= 1'b0;

      if (strobeAct[S_NMICFG]) nmiEn <= !SDA_L[2];
      if (strobeAct[S_REPWR])  reply <= SDD_IN;
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRESET) state <= NMI_IDLE;
    else         state <= nextState;
  end

  // NOTE: nextState is given a default before any branch so that no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    nextState = state;
    if (strobeAct[S_SDW]) begin
      // A new command re-arms from IDLE. It also re-arms when the old command
      // is taken in the same cycle. Otherwise the NMI sequence already under
      // way carries on.
      if (cmdTaken || state == NMI_IDLE) nextState = NMI_ARM;
    end else if (cmdTaken) begin
      nextState = NMI_IDLE;
    end else if (state == NMI_ARM && nmiEn) begin
      nextState = NMI_ASSERT;
    end
  end

  assign nZ80NMI     = (state != NMI_ASSERT);
  assign CMD_PENDING = cmdPending;
  assign OVERRUN     = overrun;
  assign M68K_REPLY  = reply;
  assign SDD_OUT     = strobeLvl[S_CMDRD] ? cmd : 8'hFF;

endmodule

// File: doc/z80_mailbox.md
Z80_MAILBOX -- requirements
Module: z80_mailbox

Interface
REQ-001 CLK  in  1  system clock; every register in the block updates on its rising edge.
REQ-002 nRESET  in  1  reset; synchronous and active-low.
REQ-003 nSDW  in  1  68k sound-command write strobe, active-low level, synchronous to CLK.
REQ-004 M68K_DIN  in  8  68k command byte, valid while nSDW is low.
REQ-005 M68K_REPLY  out  8  reply byte returned to the 68k.
REQ-006 nM68K_RRD  in  1  68k reply-read strobe, active-low level.
REQ-007 nIORQ, nSDRD, nSDWR  in  1 each  Z80 I/O request, read strobe and write strobe, active-low.
REQ-008 SDA_L  in  3  Z80 address bits [4:2].
REQ-009 SDD_IN  in  8  Z80 data bus, write direction.
REQ-010 SDD_OUT  out  8  Z80 read data; equals CMD while a command-port read is in progress, else 8'hFF.
REQ-011 nZ80NMI  out  1  NMI to the Z80, active-low.
REQ-012 CMD_PENDING  out  1  a command has been written and not yet read by the Z80.
REQ-013 OVERRUN  out  1  sticky flag: the 68k wrote a command while CMD_PENDING was 1.

Function
REQ-014 I/O read IORD = !nIORQ & !nSDRD; I/O write IOWR = !nIORQ & !nSDWR.
REQ-015 Port decode on SDA_L[3:2]:
- 00 read = CMDRD; 00 write = CMDCLR.
- 10 write = NMICFG.
- 11 write = REPWR.
- All other port/direction combinations are ignored.
REQ-016 Each strobe (nSDW, nM68K_RRD, CMDRD, CMDCLR, NMICFG, REPWR) acts once per access, on its first sampled-active cycle (previous sample inactive).
REQ-017 Each action's register effect is visible one CLK cycle after that first active sample.
REQ-018 A strobe held active for many cycles produces no repeat action.
REQ-019 nSDW action:
- CMD <= M68K_DIN.
- CMD_PENDING <= 1.
- OVERRUN <= 1 if CMD_PENDING was already 1.
REQ-020 CMDRD action: CMD_PENDING <= 0 and NMI state machine -> IDLE; CMD is unchanged.
REQ-021 CMDCLR action: CMD <= 8'h00 and CMD_PENDING <= 0.
REQ-022 NMICFG action: NMI_EN <= !SDA_L[4], so port $08 enables NMI and port $18 disables it.
REQ-023 REPWR action: REPLY <= SDD_IN.
REQ-024 nM68K_RRD action: OVERRUN <= 0; M68K_REPLY drives REPLY continuously.
REQ-025 NMI state machine states IDLE, ARM, ASSERT; nZ80NMI = 0 only in ASSERT.
REQ-026 IDLE -> ARM on an nSDW action.
REQ-027 ARM -> ASSERT on the next cycle if NMI_EN = 1.
REQ-028 ARM waits while NMI_EN = 0; an NMICFG that enables NMI then moves ARM -> ASSERT one cycle later.
REQ-029 ASSERT -> IDLE on a CMDRD or CMDCLR action.
REQ-030 Clearing NMI_EN while in ASSERT does not deassert NMI.
REQ-031 nSDW action while in ARM or ASSERT: state is unchanged and CMD is overwritten.
REQ-032 Simultaneous nSDW and CMDRD (or CMDCLR) actions in one cycle:
- the 68k write wins: CMD = new byte, CMD_PENDING = 1;
- state -> ARM regardless of its prior value;
- OVERRUN is set only if CMD_PENDING was 1 before that cycle.
REQ-033 Simultaneous nM68K_RRD action and an overrunning nSDW action: OVERRUN ends at 1.
REQ-034 SDD_OUT is combinational from IORD and the decode; it is not gated by edge detection.

Reset
REQ-035 nRESET sampled low sets, after that edge:
- CMD = 8'h00, REPLY = 8'h00;
- CMD_PENDING = 0, OVERRUN = 0;
- NMI_EN = 0, state = IDLE, nZ80NMI = 1;
- all edge-detect history = inactive.
REQ-036 Reset overrides every simultaneous action, including mid-ASSERT.
REQ-037 A strobe already held active when reset releases does not act until it goes inactive and active again.

Verification
REQ-038 Bench scenarios:
- NMICFG port $08, then 68k writes 8'h5A -> CMD_PENDING = 1 one cycle later, nZ80NMI = 0 two cycles later; Z80 reads port $00 -> SDD_OUT = 8'h5A, then nZ80NMI = 1 and CMD_PENDING = 0.
- NMI disabled, 68k writes 8'h12 -> nZ80NMI stays 1; NMICFG port $08 -> nZ80NMI = 0 one cycle after ARM sees NMI_EN = 1.
- Two 68k writes (8'h01 then 8'h02) with no Z80 read -> CMD = 8'h02, OVERRUN = 1; 68k reply read -> OVERRUN = 0.
- 68k write 8'h33 in the same cycle as Z80 CMDRD -> CMD = 8'h33, CMD_PENDING = 1, NMI reasserts.
- Z80 writes port $0C with 8'hA5 -> M68K_REPLY = 8'hA5; port $00 write -> CMD = 8'h00, NMI released.
- nRESET low while nZ80NMI = 0 -> nZ80NMI = 1, all registers cleared; a held nSDW does not act until it is re-asserted.
